log2_approx_pipe: RTL and testbench
===================================

Name: log2_approx_pipe

Overview:
- Parametrised successor to the softmax fixed-point log2 stage.
- Computes log2 of an unsigned fixed-point input as signed Q(OUT_INT).(OUT_FRAC).
- Runtime mode selects plain Mitchell or Mitchell with a shift-add quadratic correction.
- 3-stage elastic pipeline with valid/ready backpressure, a zero-input flag and a sideband bypass word. Sits between the max-subtract/exp path and the tree accumulator of the softmax datapath.

Parameters:
- IN_W, 32, input width (unsigned).
- IN_FRAC, 10, fractional bits of input.
- OUT_INT, 6, signed integer bits of result.
- OUT_FRAC, 10, fractional bits of result.
- BYP_W, 16, sideband bypass width.
- Constraint: OUT_INT must hold the range -IN_FRAC..IN_W-1-IN_FRAC in two's complement. Elaboration error otherwise.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept an input beat this cycle.
- i_in  in  IN_W  input value, Q(IN_W-IN_FRAC).IN_FRAC, unsigned.
- i_byp  in  BYP_W  sideband word; travels with the data, unmodified.
- i_mode  in  1  0 = Mitchell, 1 = corrected. Sampled with the beat.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output.
- o_log2  out  OUT_INT+OUT_FRAC  signed result.
- o_zero  out  1  input was zero.
- o_byp  out  BYP_W  sideband word, aligned with o_log2.

Behaviour:
- Stages:
  - S0 captures {mode, byp, in}.
  - S1 computes the leading-one position p (0..IN_W-1) plus a zero flag, and carries the data.
  - S2 computes the int/frac parts, applies the correction and formats the result. S2 is the output register.
- Handshake:
  - Stage k loads when its valid is 0 or stage k+1 loads. S2 "loads" when !o_valid or i_ready.
  - o_ready = S0 load condition (combinational from the valids and i_ready; no combinational path from i_in).
  - Input accepted on i_valid & o_ready. Output transferred on o_valid & i_ready.
  - Bubbles collapse.
  - Latency 3 cycles from accept to o_valid when unstalled. Throughput 1 beat/cycle.
- Stall: while o_valid & !i_ready, o_log2/o_zero/o_byp/o_valid hold stable. No beat lost or duplicated. Order preserved.
- Integer part: int = p - IN_FRAC, sign-extended/truncated to OUT_INT bits.
- Fractional part:
  - f = the OUT_FRAC bits immediately below the leading one, MSB-aligned.
  - Zero-padded on the right when fewer than OUT_FRAC bits exist below p.
  - Truncated, no rounding.
- Correction (mode=1):
  - q = (f * (2^OUT_FRAC - f)) >> OUT_FRAC, unsigned.
  - c = (q>>2) + (q>>4) + (q>>5).
  - f' = f + c, computed in OUT_FRAC+1 bits. If f' >= 2^OUT_FRAC, saturate f' to 2^OUT_FRAC-1 (no carry into int).
  - mode=0: f' = f.
- Result: o_log2 = {int, f'}.
- Zero input: o_zero=1, o_log2 = most negative value (MSB=1, rest 0), regardless of mode.
- o_byp is always i_byp of the same beat. Mode is per-beat; mixed modes back-to-back are legal.
- Reset: all stage valids cleared; o_valid=0, o_log2=0, o_zero=0, o_byp=0. o_ready=1 the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight beats. No output for them afterwards.

Test Plan:
- Defaults, mode=0: i_in=0x400 (1.0) -> o_log2=0x0000. i_in=0x800 -> 0x0400. i_in=0x600 -> 0x0200. Each 3 cycles after accept, i_ready=1.
- mode=1: i_in=0x600 -> 0x0258 (q=256, c=88). i_in=0x400 -> 0x0000. i_in=0xFFFFFFFF -> 0x57FF in both modes.
- Extremes: i_in=0x1 -> 0xD800. i_in=0 -> o_zero=1, o_log2=0x8000. Both with i_byp=0xA5A5 returned intact on o_byp.
- Backpressure: stream 8 beats (i_in=0x400<<k, k=0..7, alternating mode) with i_ready toggled pseudo-randomly. Outputs must be 0x0000,0x0400,...,0x1C00 in order. Outputs stable during stalls. o_ready=0 only when all 3 stages are full and i_ready=0.
- Reset: assert i_rst for 1 cycle with 3 beats in flight -> o_valid=0 next cycle. No stale beat ever emerges. A new beat accepted right after reset produces its result 3 cycles later.
- Parameter sweep: IN_W=16, IN_FRAC=8, OUT_FRAC=12. i_in=0x0180 -> int 0, f=0x800 (mode 0). i_in=0x0001 -> int -8.

Source files
------------

// File: rtl/log2_approx_pipe_if.sv
// Beat bundle for log2_approx_pipe: upstream value/sideband in, downstream log2 result out.
// The design side uses the slave modport; the producer/consumer side uses master.
interface log2_approx_pipe_if #(
   parameter int IN_W  = 32,
   parameter int BYP_W = 16,
   parameter int OUT_W = 16
);
   logic             i_valid;
   logic             o_ready;
   logic [IN_W-1:0]  i_in;
   logic [BYP_W-1:0] i_byp;
   logic             i_mode;
   logic             o_valid;
   logic             i_ready;
   logic [OUT_W-1:0] o_log2;
   logic             o_zero;
   logic [BYP_W-1:0] o_byp;

   modport master (output i_valid, i_in, i_byp, i_mode, i_ready,
                   input  o_ready, o_valid, o_log2, o_zero, o_byp);
   modport slave  (input  i_valid, i_in, i_byp, i_mode, i_ready,
                   output o_ready, o_valid, o_log2, o_zero, o_byp);
endinterface

// File: rtl/log2_approx_pipe.sv
// Fixed-point log2 (Mitchell, optionally with quadratic shift-add correction) in a
// 3-stage elastic pipeline: capture, leading-one detect, fraction/correct/format.
module log2_approx_pipe #(
   parameter int IN_W     = 32,
   parameter int IN_FRAC  = 10,
   parameter int OUT_INT  = 6,
   parameter int OUT_FRAC = 10,
   parameter int BYP_W    = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   log2_approx_pipe_if.slave bus
);
   localparam int OUT_W  = OUT_INT + OUT_FRAC;
   localparam int POS_W  = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int INT_LO = -(1 << (OUT_INT - 1));
   localparam int INT_HI = (1 << (OUT_INT - 1)) - 1;
   localparam logic signed [OUT_W-1:0] MOST_NEG = {1'b1, {(OUT_W-1){1'b0}}};

   if ((-IN_FRAC < INT_LO) || (IN_W - 1 - IN_FRAC > INT_HI)) begin : g_range_check
      $error("log2_approx_pipe: OUT_INT=%0d cannot hold integer range %0d..%0d",
             OUT_INT, -IN_FRAC, IN_W - 1 - IN_FRAC);
   end

   function automatic logic [OUT_FRAC-1:0] sat_frac(input logic [OUT_FRAC:0] s);
      return s[OUT_FRAC] ? {OUT_FRAC{1'b1}} : s[OUT_FRAC-1:0];
   endfunction

   // f + (q/4 + q/16 + q/32) with q = f*(1-f), a cheap fit of log2(1+x) - x.
   function automatic logic [OUT_FRAC-1:0] quad_correct(input logic [OUT_FRAC-1:0] f);
      logic [OUT_FRAC:0]   comp;
      logic [2*OUT_FRAC:0] prod;
      logic [OUT_FRAC:0]   q;
      logic [OUT_FRAC:0]   c;
      comp = {1'b1, {OUT_FRAC{1'b0}}} - {1'b0, f};
      prod = {{(OUT_FRAC+1){1'b0}}, f} * {{OUT_FRAC{1'b0}}, comp};
      q    = (OUT_FRAC+1)'(prod >> OUT_FRAC);
      c    = (q >> 2) + (q >> 4) + (q >> 5);
      return sat_frac({1'b0, f} + c);
   endfunction

   logic                     ld_p0, ld_p1, ld_p2;
   logic                     vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
   logic [IN_W-1:0]          in_p0_q, in_p0_d, in_p1_q, in_p1_d;
   logic [BYP_W-1:0]         byp_p0_q, byp_p0_d, byp_p1_q, byp_p1_d, byp_p2_q, byp_p2_d;
   logic                     mode_p0_q, mode_p0_d, mode_p1_q, mode_p1_d;
   logic [POS_W-1:0]         pos_p1_q, pos_p1_d;
   logic                     zero_p1_q, zero_p1_d, zero_p2_q, zero_p2_d;
   logic signed [OUT_W-1:0]  log2_p2_q, log2_p2_d;

   logic [POS_W-1:0]         lead_pos;
   logic                     lead_zero;
   logic signed [OUT_INT-1:0] int_part;
   logic [OUT_FRAC-1:0]      frac_raw;
   logic [OUT_FRAC-1:0]      frac_fix;

   // ---- S0 -> S1 boundary: leading-one position of the captured value
   always_comb begin
      lead_pos  = '0;
      lead_zero = 1'b1;
      for (int i = 0; i < IN_W; i++) begin
         if (in_p0_q[i]) begin
            lead_pos  = POS_W'(i);
            lead_zero = 1'b0;
         end
      end
   end

   // ---- S1 -> S2 boundary: integer part, MSB-aligned fraction, optional correction
   always_comb begin
      int_part = OUT_INT'(32'(pos_p1_q) - 32'(IN_FRAC));
      frac_raw = OUT_FRAC'({in_p1_q, {OUT_FRAC{1'b0}}} >> pos_p1_q);
      frac_fix = mode_p1_q ? quad_correct(frac_raw) : frac_raw;
   end

   always_comb begin
      ld_p2 = !vld_p2_q || bus.i_ready;
      ld_p1 = !vld_p1_q || ld_p2;
      ld_p0 = !vld_p0_q || ld_p1;

      vld_p0_d  = ld_p0 ? bus.i_valid : vld_p0_q;
      in_p0_d   = in_p0_q;
      byp_p0_d  = byp_p0_q;
      mode_p0_d = mode_p0_q;
      if (ld_p0 && bus.i_valid) begin
         in_p0_d   = bus.i_in;
         byp_p0_d  = bus.i_byp;
         mode_p0_d = bus.i_mode;
      end

      vld_p1_d  = ld_p1 ? vld_p0_q : vld_p1_q;
      in_p1_d   = in_p1_q;
      byp_p1_d  = byp_p1_q;
      mode_p1_d = mode_p1_q;
      pos_p1_d  = pos_p1_q;
      zero_p1_d = zero_p1_q;
      if (ld_p1 && vld_p0_q) begin
         in_p1_d   = in_p0_q;
         byp_p1_d  = byp_p0_q;
         mode_p1_d = mode_p0_q;
         pos_p1_d  = lead_pos;
         zero_p1_d = lead_zero;
      end

      vld_p2_d  = ld_p2 ? vld_p1_q : vld_p2_q;
      log2_p2_d = log2_p2_q;
      zero_p2_d = zero_p2_q;
      byp_p2_d  = byp_p2_q;
      if (ld_p2 && vld_p1_q) begin
         log2_p2_d = zero_p1_q ? MOST_NEG : {int_part, frac_fix};
         zero_p2_d = zero_p1_q;
         byp_p2_d  = byp_p1_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_p0_q  <= 1'b0;
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         log2_p2_q <= '0;
         zero_p2_q <= 1'b0;
         byp_p2_q  <= '0;
      end else begin
         vld_p0_q  <= vld_p0_d;
         vld_p1_q  <= vld_p1_d;
         vld_p2_q  <= vld_p2_d;
         log2_p2_q <= log2_p2_d;
         zero_p2_q <= zero_p2_d;
         byp_p2_q  <= byp_p2_d;
      end
      in_p0_q   <= in_p0_d;
      byp_p0_q  <= byp_p0_d;
      mode_p0_q <= mode_p0_d;
      in_p1_q   <= in_p1_d;
      byp_p1_q  <= byp_p1_d;
      mode_p1_q <= mode_p1_d;
      pos_p1_q  <= pos_p1_d;
      zero_p1_q <= zero_p1_d;
   end

   assign bus.o_ready = ld_p0;
   assign bus.o_valid = vld_p2_q;
   assign bus.o_log2  = log2_p2_q;
   assign bus.o_zero  = zero_p2_q;
   assign bus.o_byp   = byp_p2_q;
endmodule

// File: tb/tb_log2_approx_pipe.sv
// Bench for log2_approx_pipe: default build plus a narrow build, both scored against
// an arithmetic log2 model, with directed literals, backpressure, reset and random traffic.
module tb_log2_approx_pipe;
   localparam int A_IN_W = 32, A_IF = 10, A_OI = 6, A_OF = 10;
   localparam int B_IN_W = 16, B_IF = 8,  B_OI = 6, B_OF = 12;
   localparam int BYP_W  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   log2_approx_pipe_if #(.IN_W(A_IN_W), .BYP_W(BYP_W), .OUT_W(A_OI + A_OF)) ia ();
   log2_approx_pipe_if #(.IN_W(B_IN_W), .BYP_W(BYP_W), .OUT_W(B_OI + B_OF)) ib ();

   log2_approx_pipe #(.IN_W(A_IN_W), .IN_FRAC(A_IF), .OUT_INT(A_OI), .OUT_FRAC(A_OF), .BYP_W(BYP_W))
      dut_a (.i_clk(clk), .i_rst(rst), .bus(ia.slave));
   log2_approx_pipe #(.IN_W(B_IN_W), .IN_FRAC(B_IF), .OUT_INT(B_OI), .OUT_FRAC(B_OF), .BYP_W(BYP_W))
      dut_b (.i_clk(clk), .i_rst(rst), .bus(ib.slave));

   typedef struct {
      logic [63:0] val;
      logic        zero;
      logic [15:0] byp;
   } exp_t;

   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [63:0] got_a[$];
   logic [63:0] got_b[$];
   int          checks = 0;
   int          failures = 0;
   bit          rdy_rand = 1'b0;
   logic        rdy_val = 1'b1;

   // log2 from first principles: p = floor(log2 x), fraction = (x/2^p - 1) scaled and truncated.
   function automatic longint model_log2(input longint x, input int in_frac, input int out_int,
                                         input int out_frac, input logic mode);
      longint p, f, q, c, one, ip;
      one = longint'(1) << out_frac;
      if (x == 0) return longint'(1) << (out_int + out_frac - 1);
      p = 0;
      while ((x >> (p + 1)) != 0) p++;
      f = ((x - (longint'(1) << p)) * one) >> p;
      if (mode) begin
         q = (f * (one - f)) / one;
         c = q / 4 + q / 16 + q / 32;
         f = f + c;
         if (f > one - 1) f = one - 1;
      end
      ip = (p - in_frac) & ((longint'(1) << out_int) - 1);
      return ip * one + f;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      ia.i_ready = 1'b1;
      ib.i_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         ia.i_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_val;
         ib.i_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   logic        stall_a = 1'b0;
   logic        after_rst = 1'b0;
   logic [15:0] hold_log2, hold_byp;
   logic        hold_zero;

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            q_a.delete();
            q_b.delete();
            stall_a   = 1'b0;
            after_rst = 1'b1;
         end else begin
            if (after_rst) begin
               chk("post_rst_valid_a", ia.o_valid, 1'b0);
               chk("post_rst_valid_b", ib.o_valid, 1'b0);
               chk("post_rst_ready_a", ia.o_ready, 1'b1);
               after_rst = 1'b0;
            end
            if (stall_a) begin
               chk("stall_valid", ia.o_valid, 1'b1);
               chk("stall_log2", ia.o_log2, hold_log2);
               chk("stall_zero", ia.o_zero, hold_zero);
               chk("stall_byp", ia.o_byp, hold_byp);
            end
            chk("o_ready_a", ia.o_ready, !(q_a.size() == 3 && !ia.i_ready));
            chk("o_ready_b", ib.o_ready, !(q_b.size() == 3 && !ib.i_ready));
            if (ia.o_valid && ia.i_ready) begin
               if (q_a.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL stray_out_a: got 0x%0h expected no beat", ia.o_log2);
               end else begin
                  e = q_a.pop_front();
                  chk("log2_a", ia.o_log2, e.val);
                  chk("zero_a", ia.o_zero, e.zero);
                  chk("byp_a", ia.o_byp, e.byp);
                  got_a.push_back(64'(ia.o_log2));
               end
            end
            if (ib.o_valid && ib.i_ready) begin
               if (q_b.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL stray_out_b: got 0x%0h expected no beat", ib.o_log2);
               end else begin
                  e = q_b.pop_front();
                  chk("log2_b", ib.o_log2, e.val);
                  chk("zero_b", ib.o_zero, e.zero);
                  chk("byp_b", ib.o_byp, e.byp);
                  got_b.push_back(64'(ib.o_log2));
               end
            end
            stall_a   = ia.o_valid && !ia.i_ready;
            hold_log2 = ia.o_log2;
            hold_zero = ia.o_zero;
            hold_byp  = ia.o_byp;
            if (ia.i_valid && ia.o_ready) begin
               e.val  = 64'(model_log2(longint'(ia.i_in), A_IF, A_OI, A_OF, ia.i_mode));
               e.zero = (ia.i_in == 0);
               e.byp  = ia.i_byp;
               q_a.push_back(e);
            end
            if (ib.i_valid && ib.o_ready) begin
               e.val  = 64'(model_log2(longint'(ib.i_in), B_IF, B_OI, B_OF, ib.i_mode));
               e.zero = (ib.i_in == 0);
               e.byp  = ib.i_byp;
               q_b.push_back(e);
            end
         end
      end
   end

   task automatic drain_a();
      int n = 0;
      while ((q_a.size() != 0 || ia.o_valid) && n < 300) begin @(negedge clk); n++; end
      chk("drain_a", q_a.size(), 0);
   endtask

   task automatic drain_b();
      int n = 0;
      while ((q_b.size() != 0 || ib.o_valid) && n < 300) begin @(negedge clk); n++; end
      chk("drain_b", q_b.size(), 0);
   endtask

   // Called just after a rising edge; holds the beat until it is accepted.
   task automatic send_a(input logic [31:0] x, input logic m, input logic [15:0] b);
      int   n = 0;
      logic acc;
      ia.i_valid = 1'b1; ia.i_in = x; ia.i_mode = m; ia.i_byp = b;
      do begin
         @(negedge clk); acc = ia.o_ready;
         @(posedge clk); #1; n++;
      end while (!acc && n < 100);
      ia.i_valid = 1'b0;
      chk("send_a_accept", acc, 1'b1);
   endtask

   task automatic send_b(input logic [15:0] x, input logic m, input logic [15:0] b);
      int   n = 0;
      logic acc;
      ib.i_valid = 1'b1; ib.i_in = x; ib.i_mode = m; ib.i_byp = b;
      do begin
         @(negedge clk); acc = ib.o_ready;
         @(posedge clk); #1; n++;
      end while (!acc && n < 100);
      ib.i_valid = 1'b0;
      chk("send_b_accept", acc, 1'b1);
   endtask

   // Single beat into an empty pipe with i_ready=1: literal result and 3-cycle latency.
   task automatic directed_a(input logic [31:0] x, input logic m, input logic [15:0] b,
                             input logic [63:0] ev, input logic ez);
      int n;
      rdy_rand = 1'b0; rdy_val = 1'b1;
      drain_a();
      @(posedge clk); #1;
      ia.i_valid = 1'b1; ia.i_in = x; ia.i_mode = m; ia.i_byp = b;
      @(posedge clk); #1;
      ia.i_valid = 1'b0;
      n = 1;
      while (!ia.o_valid && n < 10) begin @(posedge clk); #1; n++; end
      chk("latency_a", n, 3);
      chk("dir_log2", ia.o_log2, ev);
      chk("dir_zero", ia.o_zero, ez);
      chk("dir_byp", ia.o_byp, b);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] x;
      ia.i_valid = 1'b0; ia.i_in = '0; ia.i_byp = '0; ia.i_mode = 1'b0;
      ib.i_valid = 1'b0; ib.i_in = '0; ib.i_byp = '0; ib.i_mode = 1'b0;

      chk("model_1p0", 64'(model_log2(64'h400, A_IF, A_OI, A_OF, 1'b0)), 64'h0000);
      chk("model_2p0", 64'(model_log2(64'h800, A_IF, A_OI, A_OF, 1'b0)), 64'h0400);
      chk("model_1p5_m0", 64'(model_log2(64'h600, A_IF, A_OI, A_OF, 1'b0)), 64'h0200);
      chk("model_1p5_m1", 64'(model_log2(64'h600, A_IF, A_OI, A_OF, 1'b1)), 64'h0258);
      chk("model_max_m1", 64'(model_log2(64'hFFFFFFFF, A_IF, A_OI, A_OF, 1'b1)), 64'h57FF);
      chk("model_one_lsb", 64'(model_log2(64'h1, A_IF, A_OI, A_OF, 1'b0)), 64'hD800);
      chk("model_zero", 64'(model_log2(64'h0, A_IF, A_OI, A_OF, 1'b1)), 64'h8000);
      chk("model_b_180", 64'(model_log2(64'h180, B_IF, B_OI, B_OF, 1'b0)), 64'h00800);
      chk("model_b_1", 64'(model_log2(64'h1, B_IF, B_OI, B_OF, 1'b0)), 64'h38000);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_o_valid", ia.o_valid, 1'b0);
      chk("rst_o_log2", ia.o_log2, 16'h0000);
      chk("rst_o_zero", ia.o_zero, 1'b0);
      chk("rst_o_byp", ia.o_byp, 16'h0000);

      directed_a(32'h400, 1'b0, 16'h1111, 64'h0000, 1'b0);
      directed_a(32'h800, 1'b0, 16'h2222, 64'h0400, 1'b0);
      directed_a(32'h600, 1'b0, 16'h3333, 64'h0200, 1'b0);
      directed_a(32'h600, 1'b1, 16'h4444, 64'h0258, 1'b0);
      directed_a(32'h400, 1'b1, 16'h5555, 64'h0000, 1'b0);
      directed_a(32'hFFFFFFFF, 1'b0, 16'h6666, 64'h57FF, 1'b0);
      directed_a(32'hFFFFFFFF, 1'b1, 16'h7777, 64'h57FF, 1'b0);
      directed_a(32'h1, 1'b0, 16'hA5A5, 64'hD800, 1'b0);
      directed_a(32'h0, 1'b0, 16'hA5A5, 64'h8000, 1'b1);
      directed_a(32'h0, 1'b1, 16'hA5A5, 64'h8000, 1'b1);

      drain_a();
      got_a.delete();
      @(posedge clk); #1;
      rdy_rand = 1'b1;
      for (int k = 0; k < 8; k++) send_a(32'h400 << k, k[0], 16'(k));
      rdy_rand = 1'b0;
      drain_a();
      chk("bp_count", got_a.size(), 8);
      for (int k = 0; k < got_a.size(); k++) chk("bp_order", got_a[k], 64'(k * 32'h400));

      @(posedge clk); #1;
      rdy_rand = 1'b1;
      repeat (150) begin
         x = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 15) == 0) x = 0;
         send_a(x, 1'($urandom_range(0, 1)), 16'($urandom));
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
      rdy_rand = 1'b0;
      drain_a();

      rdy_val = 1'b0;
      @(posedge clk); #2;
      send_a(32'h1234, 1'b0, 16'hBEEF);
      send_a(32'h5678, 1'b1, 16'hCAFE);
      send_a(32'h9ABC, 1'b0, 16'hF00D);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rdy_val = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      directed_a(32'h800, 1'b1, 16'h0F0F, 64'h0400, 1'b0);
      drain_a();

      got_b.delete();
      @(posedge clk); #1;
      send_b(16'h0180, 1'b0, 16'h0B01);
      send_b(16'h0001, 1'b0, 16'h0B02);
      send_b(16'h0180, 1'b1, 16'h0B03);
      drain_b();
      chk("b_count", got_b.size(), 3);
      if (got_b.size() >= 2) begin
         chk("b_180_m0", got_b[0], 64'h00800);
         chk("b_1_m0", got_b[1], 64'h38000);
      end
      @(posedge clk); #1;
      rdy_rand = 1'b1;
      repeat (80) begin
         send_b(16'($urandom) >> $urandom_range(0, 15), 1'($urandom_range(0, 1)), 16'($urandom));
      end
      rdy_rand = 1'b0;
      drain_b();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
